// File: rtl/auth_sequencer_pkg.sv
// Shared definitions for the authentication sequencer: state encodings,
// field widths and the saturating failure-count helper.
package auth_sequencer_pkg;

    localparam int USER_ID_W  = 5;
    localparam int FAIL_CNT_W = 4;

    typedef enum logic [1:0] {
        S_ID    = 2'b00,
        S_PSWD  = 2'b01,
        S_GRANT = 2'b10,
        S_LOCK  = 2'b11
    } state_e;

    // Increment a failure count, holding it at max_cnt so the 4-bit field never wraps.
    function automatic logic [FAIL_CNT_W-1:0] fail_inc(
        input logic [FAIL_CNT_W-1:0] cnt,
        input logic [FAIL_CNT_W-1:0] max_cnt
    );
        logic [FAIL_CNT_W-1:0] res;
        if (cnt >= max_cnt) begin
            res = max_cnt;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/auth_cycle_timer.sv
// Loadable up-counter with clear and a terminal-count flag at TERMINAL-1.
// Used for both the lockout period and the password-entry timeout.
module auth_cycle_timer #(
    parameter int TERMINAL = 8,
    parameter int CNT_W    = (TERMINAL > 1) ? $clog2(TERMINAL) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear beats load, load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/auth_sequencer.sv
// Top-level login sequencer: ID check, then password check, with a
// consecutive-failure lockout, a password-entry timeout and session hold.
module auth_sequencer
    import auth_sequencer_pkg::*;
#(
    parameter int MAX_ATTEMPTS  = 3,
    parameter int LOCK_CYCLES   = 50000000,
    parameter int ENTRY_TIMEOUT = 250000000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  EnterPswd,
    input  logic                  LogOutPulse,
    input  logic                  IDOK,
    input  logic                  IDFail,
    input  logic [USER_ID_W-1:0]  InternalID,
    input  logic                  PswdOK,
    input  logic                  PswdFail,
    output logic                  IDEnable,
    output logic                  PswdEnable,
    output logic                  ClearCheckers,
    output logic                  LoggedIn,
    output logic                  LockedOut,
    output logic [USER_ID_W-1:0]  UserID,
    output logic [FAIL_CNT_W-1:0] FailCount
);

    localparam logic [FAIL_CNT_W-1:0] MAX_FAIL = FAIL_CNT_W'(MAX_ATTEMPTS);

    state_e                  state_q, state_d;
    logic [USER_ID_W-1:0]    user_id_q, user_id_d;
    logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic                    clear_q, clear_d;
    logic                    id_en_q, id_en_d;
    logic                    pswd_en_q, pswd_en_d;
    logic                    logged_in_q, logged_in_d;
    logic                    locked_out_q, locked_out_d;

    logic                    lock_tc_s;
    logic                    entry_tc_s;
    logic                    timeout_s;

    // An EnterPswd press in the terminal cycle restarts the window instead of aborting.
    assign timeout_s = entry_tc_s && !EnterPswd;

    auth_cycle_timer #(.TERMINAL(LOCK_CYCLES)) u_lock_timer (
        .clk        (Clk),
        .rst_n      (Reset),
        .clr_i      ((state_q != S_LOCK) || lock_tc_s),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (state_q == S_LOCK),
        .tc_o       (lock_tc_s)
    );

    auth_cycle_timer #(.TERMINAL(ENTRY_TIMEOUT)) u_entry_timer (
        .clk        (Clk),
        .rst_n      (Reset),
        .clr_i      ((state_q != S_PSWD) || EnterPswd),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (state_q == S_PSWD),
        .tc_o       (entry_tc_s)
    );

    // Next-state and next-output decode; abort beats fail beats OK beats timeout.
    always_comb begin
        state_d    = state_q;
        user_id_d  = user_id_q;
        fail_cnt_d = fail_cnt_q;
        clear_d    = 1'b0;
        case (state_q)
            S_ID: begin
                if (LogOutPulse) begin
                    clear_d   = 1'b1;
                    user_id_d = '0;
                end else if (IDFail) begin
                    fail_cnt_d = fail_inc(fail_cnt_q, MAX_FAIL);
                    clear_d    = 1'b1;
                    if (fail_cnt_d == MAX_FAIL) begin
                        state_d = S_LOCK;
                    end else begin
                        state_d = S_ID;
                    end
                end else if (IDOK) begin
                    user_id_d = InternalID;
                    state_d   = S_PSWD;
                end else begin
                    state_d = S_ID;
                end
            end
            S_PSWD: begin
                if (LogOutPulse) begin
                    state_d   = S_ID;
                    clear_d   = 1'b1;
                    user_id_d = '0;
                end else if (PswdFail) begin
                    fail_cnt_d = fail_inc(fail_cnt_q, MAX_FAIL);
                    clear_d    = 1'b1;
                    user_id_d  = '0;
                    if (fail_cnt_d == MAX_FAIL) begin
                        state_d = S_LOCK;
                    end else begin
                        state_d = S_ID;
                    end
                end else if (PswdOK) begin
                    state_d    = S_GRANT;
                    fail_cnt_d = '0;
                end else if (timeout_s) begin
                    state_d   = S_ID;
                    clear_d   = 1'b1;
                    user_id_d = '0;
                end else begin
                    state_d = S_PSWD;
                end
            end
            S_GRANT: begin
                if (LogOutPulse) begin
                    state_d   = S_ID;
                    clear_d   = 1'b1;
                    user_id_d = '0;
                end else begin
                    state_d = S_GRANT;
                end
            end
            S_LOCK: begin
                if (lock_tc_s) begin
                    state_d    = S_ID;
                    fail_cnt_d = '0;
                end else begin
                    state_d = S_LOCK;
                end
            end
            default: begin
                state_d    = S_ID;
                user_id_d  = '0;
                fail_cnt_d = '0;
            end
        endcase

        id_en_d      = (state_d == S_ID);
        pswd_en_d    = (state_d == S_PSWD);
        logged_in_d  = (state_d == S_GRANT);
        locked_out_d = (state_d == S_LOCK);
    end

    // State and registered-output flops.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_ID;
            user_id_q    <= '0;
            fail_cnt_q   <= '0;
            clear_q      <= 1'b0;
            id_en_q      <= 1'b1;
            pswd_en_q    <= 1'b0;
            logged_in_q  <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            user_id_q    <= user_id_d;
            fail_cnt_q   <= fail_cnt_d;
            clear_q      <= clear_d;
            id_en_q      <= id_en_d;
            pswd_en_q    <= pswd_en_d;
            logged_in_q  <= logged_in_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign IDEnable      = id_en_q;
    assign PswdEnable    = pswd_en_q;
    assign ClearCheckers = clear_q;
    assign LoggedIn      = logged_in_q;
    assign LockedOut     = locked_out_q;
    assign UserID        = user_id_q;
    assign FailCount     = fail_cnt_q;

endmodule
